conv_operand_sequencer: RTL and testbench
=========================================

Name: conv_operand_sequencer

Overview:
- Upstream feeder for the 14-bit pipelined MAC.
- Loads M filter taps and then N input samples over a valid/ready stream into internal register files.
- Issues one (a, b, valid) operand pair per cycle to the MAC for each of the N-M+1 sliding windows of a 1-D valid convolution.
- Pulses a clear between windows and waits out the MAC pipeline latency so that no partial sums mix across windows.

Parameters:
- WIDTH, 14, operand width (matches MAC a/b).
- M, 4, filter taps.
- N, 16, input vector length (N >= M).
- DRAIN, 8, idle cycles after the last pair of a window (MAC valid_in to valid_out latency).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin load/convolve run (sampled in IDLE only)
- s_valid  in  1  input stream valid
- s_data  in  WIDTH  signed stream data: M taps w[0..M-1], then N samples x[0..N-1]
- s_ready  out  1  stream ready
- issue_en  in  1  issue permission; low = bubble
- mac_a  out  WIDTH  signed operand x[j+k]
- mac_b  out  WIDTH  signed operand w[k]
- mac_valid  out  1  drives MAC valid_in
- mac_last  out  1  marks the final pair of a window
- mac_clear  out  1  one-cycle accumulator clear pulse
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse after the last window drains

Behaviour:
- Reset is synchronous and active-high; clock is clk. Reset wins over all other inputs, including mid-run: the FSM returns to IDLE and all counters are zeroed. Register-file contents are don't-care after reset.
- Reset values: s_ready=0, mac_a=0, mac_b=0, mac_valid=0, mac_last=0, mac_clear=0, busy=0, done=0.
- All outputs are registered.
- FSM states: IDLE, LOAD_W, LOAD_X, CLEAR, ISSUE, DRAIN, DONE.
- IDLE: s_ready=0. When start=1, go to LOAD_W and zero the counters.
- LOAD_W: s_ready=1. Each s_valid&s_ready stores w[cnt] and increments cnt. After the M-th accept, go to LOAD_X with cnt=0.
- LOAD_X: same rule for x[0..N-1]. After the N-th accept, set s_ready=0, window j=0, and go to CLEAR.
- s_valid low during load: hold state and counters. start is ignored outside IDLE.
- CLEAR: exactly one cycle with mac_clear=1 and mac_valid=0; k=0; go to ISSUE.
- ISSUE, issue_en=1: next cycle mac_a=x[j+k], mac_b=w[k], mac_valid=1, mac_last=(k==M-1); k increments. After k==M-1, go to DRAIN with the drain counter at 0.
- ISSUE, issue_en=0: next cycle mac_valid=0, mac_last=0; k holds. mac_a/mac_b hold their previous values.
- DRAIN: mac_valid=0 for exactly DRAIN cycles, regardless of issue_en. Then go to CLEAR with j+1 if j<N-M; otherwise go to DONE.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Timing with issue_en held high: per window 1 + M + DRAIN cycles. Consecutive pairs within a window are back-to-back.
- Index arithmetic: j+k never exceeds N-1. Counters are sized $clog2(N+1) and do not wrap.
- No arithmetic is done on data. Values are passed bit-exact and signed.

Optional Feature:
- Macro SEQ_ZERO_SKIP_EN.
- Defined: in ISSUE, taps with w[k]==0 and k<M-1 are skipped (no cycle consumed; k advances to the next nonzero tap or to M-1). Tap M-1 is always issued, even if zero, so every window emits exactly one mac_last pair.
- Not defined: every tap is issued. Cycle counts follow the formula above.

Test Plan:
- Basic run (default parameters), issue_en=1:
  - Stimulus: start, then stream w={1,2,3,4}, x={1..16} with s_valid continuous.
  - Required: 13 windows; mac_clear pulses 13 times; 52 valid pairs.
  - Required: window j pairs are (j+1,1),(j+2,2),(j+3,3),(j+4,4); MAC results are 30,40,...,150.
  - Required: done fires 13*(1+4+8)=169 cycles after the first CLEAR.
- Load backpressure: toggle s_valid 1/0 every cycle during load -> exactly 20 accepts; s_ready drops after the 20th; issued operands are identical to the basic run.
- issue_en bubbles: hold issue_en=0 for 3 cycles after the 2nd pair of window 0 -> mac_valid is low for exactly 3 cycles; pairs resume with (3,3); the pair sequence is otherwise unchanged.
- Reset mid-ISSUE in window 5:
  - Required: next cycle all outputs are 0 and the FSM is in IDLE.
  - Required: a new start plus reload produces the basic-run sequence from window 0.
- Signed extremes: w={-8192,8191,-1,0}, x all -8192 -> mac_a/mac_b carry exact 14-bit patterns (0x2000, 0x1FFF, 0x3FFF, 0x0000).
- SEQ_ZERO_SKIP_EN, w={0,2,0,0}: each window issues 2 pairs, (x[j+1],2) then (x[j+3],0) with mac_last=1. Per window 1+2+8=11 cycles.

Source files
------------

// File: rtl/conv_operand_sequencer_if.sv
// Stream-load and MAC-operand signal bundle for conv_operand_sequencer.
// slave = the sequencer; master = the stream source / MAC side.
interface conv_operand_sequencer_if #(
  parameter int WIDTH = 14
);
  logic                    s_valid;
  logic signed [WIDTH-1:0] s_data;
  logic                    s_ready;
  logic                    issue_en;
  logic signed [WIDTH-1:0] mac_a;
  logic signed [WIDTH-1:0] mac_b;
  logic                    mac_valid;
  logic                    mac_last;
  logic                    mac_clear;

  modport master (
    output s_valid, s_data, issue_en,
    input  s_ready, mac_a, mac_b, mac_valid, mac_last, mac_clear
  );

  modport slave (
    input  s_valid, s_data, issue_en,
    output s_ready, mac_a, mac_b, mac_valid, mac_last, mac_clear
  );
endinterface

// File: rtl/conv_operand_sequencer.sv
// Loads M taps and N samples, then feeds (x[j+k], w[k]) pairs to the MAC per sliding window.
// Optional macro SEQ_ZERO_SKIP_EN: skip zero taps other than the last one of each window.
module conv_operand_sequencer #(
  parameter int WIDTH = 14,
  parameter int M     = 4,
  parameter int N     = 16,
  parameter int DRAIN = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  conv_operand_sequencer_if.slave       bus,
  output logic                          busy,
  output logic                          done
);

  localparam int CW = $clog2(N + 1);
  localparam int WA = (M > 1) ? $clog2(M) : 1;
  localparam int XA = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_X,
    ST_CLEAR,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] cnt, cnt_next;
  logic [CW-1:0] j, j_next;
  logic [CW-1:0] k, k_next;
  logic [CW-1:0] tap;
  logic [DW-1:0] dcnt, dcnt_next;

  logic signed [WIDTH-1:0] w_mem [M];
  logic signed [WIDTH-1:0] x_mem [N];
  logic                    w_we, x_we;

  logic                    s_ready_q;
  logic signed [WIDTH-1:0] mac_a_q, mac_b_q, a_next, b_next;
  logic                    mac_valid_q, mac_last_q, mac_clear_q;
  logic                    valid_next, last_next;
  logic                    accept;

  assign accept        = bus.s_valid && s_ready_q;
  assign bus.s_ready   = s_ready_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.mac_valid = mac_valid_q;
  assign bus.mac_last  = mac_last_q;
  assign bus.mac_clear = mac_clear_q;

  // NOTE: the register files carry no reset; their contents are always rewritten by a load before use.
  always_ff @(posedge clk) begin
    if (w_we) w_mem[WA'(cnt)] <= bus.s_data;
    if (x_we) x_mem[XA'(cnt)] <= bus.s_data;
  end

  // NOTE: every state/output flop uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      j           <= '0;
      k           <= '0;
      dcnt        <= '0;
      s_ready_q   <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_clear_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      j           <= j_next;
      k           <= k_next;
      dcnt        <= dcnt_next;
      s_ready_q   <= (state_next == ST_LOAD_W) || (state_next == ST_LOAD_X);
      mac_a_q     <= a_next;
      mac_b_q     <= b_next;
      mac_valid_q <= valid_next;
      mac_last_q  <= last_next;
      mac_clear_q <= (state_next == ST_CLEAR);
      busy        <= (state_next != ST_IDLE);
      done        <= (state_next == ST_DONE);
    end
  end

  // NOTE: every variable gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    j_next     = j;
    k_next     = k;
    dcnt_next  = dcnt;
    a_next     = mac_a_q;
    b_next     = mac_b_q;
    valid_next = 1'b0;
    last_next  = 1'b0;
    w_we       = 1'b0;
    x_we       = 1'b0;
    tap        = k;

`ifdef SEQ_ZERO_SKIP_EN
    // Lowest nonzero tap at or above k; the last tap is taken even when zero.
    tap = CW'(M - 1);
    for (int i = M - 2; i >= 0; i--) begin
      if ((CW'(i) >= k) && (w_mem[WA'(i)] != '0)) tap = CW'(i);
    end
`endif

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOAD_W;
          cnt_next   = '0;
          j_next     = '0;
          k_next     = '0;
          dcnt_next  = '0;
        end
      end

      ST_LOAD_W: begin
        if (accept) begin
          w_we = 1'b1;
          if (cnt == CW'(M - 1)) begin
            state_next = ST_LOAD_X;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end

      ST_LOAD_X: begin
        if (accept) begin
          x_we = 1'b1;
          if (cnt == CW'(N - 1)) begin
            state_next = ST_CLEAR;
            cnt_next   = '0;
            j_next     = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        k_next     = '0;
        state_next = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (bus.issue_en) begin
          a_next     = x_mem[XA'(j) + XA'(tap)];
          b_next     = w_mem[WA'(tap)];
          valid_next = 1'b1;
          last_next  = (tap == CW'(M - 1));
          if (tap == CW'(M - 1)) begin
            state_next = ST_DRAIN;
            dcnt_next  = '0;
          end else begin
            k_next = tap + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (dcnt == DW'(DRAIN - 1)) begin
          dcnt_next = '0;
          if (j != CW'(N - M)) begin
            j_next     = j + 1'b1;
            state_next = ST_CLEAR;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          dcnt_next = dcnt + 1'b1;
        end
      end

      ST_DONE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_operand_sequencer.sv
// Directed bench for conv_operand_sequencer: loads, windows, bubbles, mid-run reset, signed data.
// Expected pair streams come from the plain convolution index model x[j+k], w[k].
module tb_conv_operand_sequencer;
  localparam int WIDTH = 14;
  localparam int M     = 4;
  localparam int N     = 16;
  localparam int DRAIN = 8;
  localparam int NW    = N - M + 1;

  typedef logic [WIDTH-1:0] wvec_t [M];
  typedef logic [WIDTH-1:0] xvec_t [N];
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             last;
  } pair_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  conv_operand_sequencer_if #(.WIDTH(WIDTH)) bus ();

  conv_operand_sequencer #(
    .WIDTH(WIDTH), .M(M), .N(N), .DRAIN(DRAIN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .bus  (bus.slave),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  pair_t got_q [$];
  int    got_cyc [$];
  int    cyc = 0;
  int    clear_cnt, done_cnt, first_clear, done_at;
  int    n_checks = 0;
  int    n_errors = 0;

  wvec_t w_basic, w_signed, w_sparse;
  xvec_t x_basic, x_signed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (bus.mac_clear) begin
      clear_cnt++;
      if (first_clear < 0) first_clear = cyc;
    end
    if (bus.mac_valid) begin
      got_q.push_back({bus.mac_a, bus.mac_b, bus.mac_last});
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_at = cyc;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
    clear_cnt   = 0;
    done_cnt    = 0;
    first_clear = -1;
    done_at     = -1;
  endtask

  function automatic bit issued(input wvec_t w, input int k);
`ifdef SEQ_ZERO_SKIP_EN
    return !((w[k] == '0) && (k < M - 1));
`else
    return 1'b1;
`endif
  endfunction

  task automatic load(input wvec_t w, input xvec_t x, input bit toggle);
    int idx   = 0;
    int guard = 0;
    bit phase = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < M + N && guard < 200) begin
      bus.s_valid = toggle ? phase : 1'b1;
      phase       = ~phase;
      bus.s_data  = (idx < M) ? w[idx] : x[idx - M];
      if (bus.s_valid && bus.s_ready) idx++;
      @(negedge clk);
      guard++;
    end
    bus.s_valid = 1'b0;
    check("load accepts", idx, M + N);
    check("s_ready drop", bus.s_ready, 1'b0);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done_cnt == 0 && guard < 3000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("done seen", done_cnt, 1);
    repeat (2) @(negedge clk);
    #1;
    check("done one pulse", done_cnt, 1);
    check("busy after done", busy, 1'b0);
  endtask

  task automatic check_run(input string tag, input wvec_t w, input xvec_t x, input bit chk_lat);
    int    e    = 0;
    int    taps = 0;
    pair_t exp_p;
    for (int k = 0; k < M; k++) if (issued(w, k)) taps++;
    for (int jj = 0; jj < NW; jj++) begin
      for (int k = 0; k < M; k++) begin
        if (issued(w, k)) begin
          exp_p = {x[jj + k], w[k], (k == M - 1)};
          if (e < got_q.size()) check($sformatf("%s pair %0d", tag, e), got_q[e], exp_p);
          e++;
        end
      end
    end
    check({tag, " pair count"}, got_q.size(), e);
    check({tag, " clear count"}, clear_cnt, NW);
    if (chk_lat) check({tag, " done latency"}, done_at - first_clear, NW * (1 + taps + DRAIN));
  endtask

  task automatic check_sums();
    int acc = 0;
    int win = 0;
    foreach (got_q[i]) begin
      acc += int'($signed(got_q[i].a)) * int'($signed(got_q[i].b));
      if (got_q[i].last) begin
        check($sformatf("window %0d sum", win), acc, 30 + 10 * win);
        win++;
        acc = 0;
      end
    end
    check("window count", win, NW);
  endtask

  initial begin
    w_basic  = '{14'd1, 14'd2, 14'd3, 14'd4};
    w_signed = '{14'h2000, 14'h1FFF, 14'h3FFF, 14'h0000};
    w_sparse = '{14'd0, 14'd2, 14'd0, 14'd0};
    for (int i = 0; i < N; i++) begin
      x_basic[i]  = WIDTH'(i + 1);
      x_signed[i] = 14'h2000;
    end

    reset        = 1'b1;
    start        = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.issue_en = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset s_ready", bus.s_ready, 1'b0);
    check("reset mac_a", bus.mac_a, '0);
    check("reset mac_b", bus.mac_b, '0);
    check("reset mac_valid", bus.mac_valid, 1'b0);
    check("reset mac_last", bus.mac_last, 1'b0);
    check("reset mac_clear", bus.mac_clear, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    reset = 1'b0;

    // Basic run
    clear_mon();
    load(w_basic, x_basic, 1'b0);
    wait_done();
    check_run("basic", w_basic, x_basic, 1'b1);
    check_sums();

    // Load backpressure
    clear_mon();
    load(w_basic, x_basic, 1'b1);
    wait_done();
    check_run("backpressure", w_basic, x_basic, 1'b1);

    // issue_en bubble after the 2nd pair of window 0
    clear_mon();
    fork
      begin
        load(w_basic, x_basic, 1'b0);
        wait_done();
      end
      begin
        int g = 0;
        while (got_q.size() < 2 && g < 500) begin
          @(negedge clk);
          #1;
          g++;
        end
        bus.issue_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        bus.issue_en = 1'b1;
      end
    join
    check("bubble back-to-back", (got_cyc.size() > 1) ? got_cyc[1] - got_cyc[0] : -1, 1);
    check("bubble gap", (got_cyc.size() > 2) ? got_cyc[2] - got_cyc[1] : -1, 4);
    check("bubble resume pair", (got_q.size() > 2) ? 32'(got_q[2]) : '1,
          32'(pair_t'({14'd3, 14'd3, 1'b0})));
    check_run("bubble", w_basic, x_basic, 1'b0);

    // Reset in the middle of window 5
    clear_mon();
    load(w_basic, x_basic, 1'b0);
    begin
      int g = 0;
      while (got_q.size() < 22 && g < 500) begin
        @(negedge clk);
        #1;
        g++;
      end
    end
    check("window 5 reached", clear_cnt, 6);
    reset = 1'b1;
    @(negedge clk);
    check("midrun reset outputs",
          {bus.s_ready, bus.mac_a, bus.mac_b, bus.mac_valid, bus.mac_last, bus.mac_clear, busy, done}, '0);
    reset = 1'b0;
    clear_mon();
    load(w_basic, x_basic, 1'b0);
    wait_done();
    check_run("after reset", w_basic, x_basic, 1'b1);

    // Signed extremes
    clear_mon();
    load(w_signed, x_signed, 1'b0);
    wait_done();
    check_run("signed", w_signed, x_signed, 1'b1);
    check("signed a0", (got_q.size() > 3) ? 32'(got_q[0].a) : '1, 32'h2000);
    check("signed b0", (got_q.size() > 3) ? 32'(got_q[0].b) : '1, 32'h2000);
    check("signed b1", (got_q.size() > 3) ? 32'(got_q[1].b) : '1, 32'h1FFF);
    check("signed b2", (got_q.size() > 3) ? 32'(got_q[2].b) : '1, 32'h3FFF);
    check("signed b3", (got_q.size() > 3) ? 32'(got_q[3].b) : '1, 32'h0000);

    // Sparse taps: skipped when SEQ_ZERO_SKIP_EN is defined, all issued otherwise
    clear_mon();
    load(w_sparse, x_basic, 1'b0);
    wait_done();
    check_run("sparse", w_sparse, x_basic, 1'b1);
`ifdef SEQ_ZERO_SKIP_EN
    check("sparse first pair", (got_q.size() > 0) ? 32'(got_q[0]) : '1,
          32'(pair_t'({14'd2, 14'd2, 1'b0})));
    check("sparse window time", done_at - first_clear, NW * 11);
`else
    check("sparse first pair", (got_q.size() > 0) ? 32'(got_q[0]) : '1,
          32'(pair_t'({14'd1, 14'd0, 1'b0})));
    check("sparse window time", done_at - first_clear, NW * 13);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
